bitdec_unit: RTL and testbench

Two-stage pipelined single-bit decode/manipulation unit; the decode-side counterpart of the ctz encoder in the execute stage. Turns a bit index or trailing-zero count (0..32, with 32 meaning "no bit", the same convention ctz produces for a zero operand) back into a one-hot or low mask, and applies that mask to `oprand1` (set, clear, invert, extract). Sits beside the ALU behind a valid/ready handshake so it can be stalled by writeback and flushed on redirect.

---
 rtl/bitdec_unit.sv | 69 ++++++
 tb/tb_bitdec_unit.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/bitdec_unit.sv
// bitdec_unit: two-stage pipelined bit-index decode and single-bit manipulation
module bitdec_unit #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [31:0]      oprand1,
  input  logic [31:0]      oprand2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);
  localparam logic [2:0] DEC = 3'd0, BSET = 3'd1, BCLR = 3'd2, BINV = 3'd3, BEXT = 3'd4, MASK = 3'd5;
  logic             s1_valid, s2_valid, s2_take, s1_adv, xfer, bitop;
  logic [2:0]       s1_op;
  logic [31:0]      s1_a, s1_onehot, s1_lomask, onehot, lomask, res, s2_result;
  logic [TAG_W-1:0] s1_tag, s2_tag;
  logic             unused_hi;
  assign unused_hi = ^oprand2[31:6];
  // oprand2[5] set means n saturates to 32; otherwise n equals oprand2[4:0]
  always_comb begin
    s2_take  = !s2_valid | out_ready;
    s1_adv   = s1_valid & s2_take;
    in_ready = !rst & (!s1_valid | s2_take);
    xfer     = in_valid & in_ready;
    bitop    = (in_op == BSET) | (in_op == BCLR) | (in_op == BINV) | (in_op == BEXT);
    onehot   = (bitop | !oprand2[5]) ? 32'd1 << oprand2[4:0] : 32'd0;
    lomask   = oprand2[5] ? 32'hFFFF_FFFF : (32'd1 << oprand2[4:0]) - 32'd1;
    res      = s1_op == DEC  ? s1_onehot :
               s1_op == BSET ? s1_a | s1_onehot :
               s1_op == BCLR ? s1_a & ~s1_onehot :
               s1_op == BINV ? s1_a ^ s1_onehot :
               s1_op == BEXT ? {31'b0, |(s1_a & s1_onehot)} :
               s1_op == MASK ? s1_lomask : 32'd0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_tag    <= '0;
    end else begin
      s1_valid <= !flush & (xfer | (s1_valid & !s1_adv));
      s2_valid <= !flush & (s1_adv | (s2_valid & !out_ready));
      if (s1_adv) begin
        s2_result <= res;
        s2_tag    <= s1_tag;
      end
    end
    if (xfer) begin
      s1_op     <= in_op;
      s1_a      <= oprand1;
      s1_tag    <= in_tag;
      s1_onehot <= onehot;
      s1_lomask <= lomask;
    end
  end
  assign out_valid  = s2_valid;
  assign out_result = s2_result;
  assign out_tag    = s2_tag;
  assign busy       = s1_valid | s2_valid;
endmodule

// File: tb/tb_bitdec_unit.sv
// tb_bitdec_unit: directed self-checking bench for bitdec_unit
module tb_bitdec_unit;
  localparam int TAG_W = 5;
  logic             clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic             in_ready, out_valid, busy;
  logic [2:0]       in_op = 0;
  logic [31:0]      oprand1 = 0, oprand2 = 0, out_result;
  logic [TAG_W-1:0] in_tag = 0, out_tag;
  int checks = 0, failures = 0;

  bitdec_unit #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .oprand1(oprand1), .oprand2(oprand2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] t, input logic [31:0] exp, input string nm);
    int n;
    in_valid = 1; in_op = op; oprand1 = a; oprand2 = b; in_tag = t; out_ready = 1;
    #1;
    n = 0;
    while (!in_ready && n < 10) begin step(); n++; end
    step();
    in_valid = 0;
    n = 0;
    while (!out_valid && n < 8) begin step(); n++; end
    chk({nm, "_lat"}, n, 1);
    chk(nm, out_result, exp);
    chk({nm, "_tag"}, 32'(out_tag), 32'(t));
    step();
  endtask

  function automatic logic [31:0] ctz(input logic [31:0] x);
    for (int i = 0; i < 32; i++) if (x[i]) return i;
    return 32;
  endfunction

  task automatic fill2();
    out_ready = 0; in_valid = 1; in_op = 3'd0;
    oprand2 = 1; in_tag = 9;  step();
    oprand2 = 2; in_tag = 10; step();
  endtask

  initial begin
    logic [31:0] xs [8];
    logic [31:0] held;
    logic hv;
    int acc, got, cyc;
    step();
    chk("rst_in_ready", in_ready, 0);
    step();
    rst = 0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_tag", 32'(out_tag), 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready_after", in_ready, 1);

    run_op(3'd0, 0, 32'h00, 1, 32'h0000_0001, "dec0");
    run_op(3'd0, 0, 32'h05, 2, 32'h0000_0020, "dec5");
    run_op(3'd0, 0, 32'h1F, 3, 32'h8000_0000, "dec31");
    run_op(3'd0, 0, 32'h20, 4, 32'h0000_0000, "dec32");
    run_op(3'd0, 0, 32'h3F, 5, 32'h0000_0000, "dec3f");
    run_op(3'd0, 0, 32'h40, 6, 32'h0000_0001, "dec40");
    run_op(3'd5, 0, 0, 7, 32'h0000_0000, "mask0");
    run_op(3'd5, 0, 4, 8, 32'h0000_000F, "mask4");
    run_op(3'd5, 0, 32, 9, 32'hFFFF_FFFF, "mask32");
    run_op(3'd1, 32'h0000_00F0, 32'h23, 10, 32'h0000_00F8, "bset");
    run_op(3'd2, 32'hFFFF_FFFF, 32'h24, 11, 32'hFFFF_FFEF, "bclr");
    run_op(3'd3, 32'h8000_0001, 31, 12, 32'h0000_0001, "binv");
    run_op(3'd4, 32'h8000_0000, 31, 13, 32'h0000_0001, "bext31");
    run_op(3'd4, 32'h8000_0000, 30, 14, 32'h0000_0000, "bext30");
    run_op(3'd6, 32'h1234_5678, 3, 15, 32'h0000_0000, "op6");

    xs = '{32'h0, 32'h1, 32'h8000_0000, 32'h0000_00A0, $urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 8; i++)
      run_op(3'd0, 0, ctz(xs[i]), 5'(i), xs[i] & (~xs[i] + 32'd1), "roundtrip");

    acc = 0; got = 0; cyc = 0; hv = 0; held = 0;
    while (got < 6 && cyc < 40) begin
      out_ready = !(cyc >= 2 && cyc <= 5);
      in_valid = acc < 6; in_op = 3'd0; oprand2 = acc + 1; in_tag = 5'(acc + 1);
      #1;
      if (hv) chk("bp_hold", out_result, held);
      hv = out_valid && !out_ready;
      held = out_result;
      if (cyc == 2) begin
        chk("bp_full_ready", in_ready, 0);
        chk("bp_accepts", acc, 2);
      end
      if (out_valid && out_ready) begin
        got++;
        chk("bp_tag", 32'(out_tag), got);
        chk("bp_res", out_result, 32'd1 << got);
      end
      if (in_valid && in_ready) acc++;
      step();
      cyc++;
    end
    in_valid = 0;
    chk("bp_got", got, 6);
    chk("bp_acc", acc, 6);
    step();
    chk("bp_drained", out_valid, 0);

    fill2();
    oprand2 = 3; in_tag = 11; flush = 1;
    #1;
    chk("flush_in_ready", in_ready, 0);
    chk("flush_busy_before", busy, 1);
    step();
    flush = 0; in_valid = 0;
    chk("flush_busy", busy, 0);
    chk("flush_out_valid", out_valid, 0);
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("flush_none_emitted", out_valid, 0);
    end
    run_op(3'd0, 0, 4, 12, 32'h0000_0010, "post_flush");

    fill2();
    in_valid = 0; rst = 1;
    #1;
    chk("midrst_in_ready", in_ready, 0);
    step();
    rst = 0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_result", out_result, 0);
    chk("midrst_in_ready_after", in_ready, 1);
    chk("midrst_busy", busy, 0);
    run_op(3'd0, 0, 3, 13, 32'h0000_0008, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
